// File: rtl/tmds_word_aligner.sv
// Receive-side TMDS word aligner: searches all 10 bit offsets for runs of control
// tokens, locks on the offset that yields them and delivers word-aligned characters.
module tmds_word_aligner #(
    parameter int LOCK_COUNT     = 16,
    parameter int SEARCH_TIMEOUT = 4096,
    parameter int LOSS_TIMEOUT   = 8192
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] raw_word,
    input  logic       raw_valid,
    output logic [9:0] aligned_word,
    output logic       aligned_valid,
    output logic       aligned_is_ctrl,
    output logic       locked,
    output logic [3:0] offset,
    output logic       lock_lost
);

    localparam int RUN_W = $clog2(LOCK_COUNT) + 1;
    localparam int TMO_W = $clog2(SEARCH_TIMEOUT) + 1;
    localparam int GAP_W = $clog2(LOSS_TIMEOUT) + 1;

    localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(LOCK_COUNT);
    localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(LOCK_COUNT - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(SEARCH_TIMEOUT - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(LOSS_TIMEOUT - 1);

    localparam logic [9:0] TOK_C0 = 10'b1101010100;
    localparam logic [9:0] TOK_C1 = 10'b0010101011;
    localparam logic [9:0] TOK_C2 = 10'b0101010100;
    localparam logic [9:0] TOK_C3 = 10'b1010101011;

    typedef enum logic {
        ST_SEARCH,
        ST_LOCKED
    } state_t;

    state_t           r_state;
    logic [9:0]       r_prev;
    logic [9:0]       r_aligned_word;
    logic             r_aligned_valid;
    logic             r_aligned_is_ctrl;
    logic             r_locked;
    logic [3:0]       r_offset;
    logic             r_lock_lost;
    logic [RUN_W-1:0] r_run;
    logic [TMO_W-1:0] r_tmo;
    logic [GAP_W-1:0] r_gap;

    logic [19:0]      w_win;
    logic [19:0]      w_shift;
    logic [9:0]       w_cand;
    logic             w_cand_ctrl;
    logic             w_lock_hit;
    logic [RUN_W-1:0] w_run_nxt;
    logic [3:0]       w_offset_nxt;

    // Older word sits in the low half, so offset 0 selects the previous raw word.
    assign w_win        = {raw_word, r_prev};
    assign w_shift      = w_win >> r_offset;
    assign w_cand       = w_shift[9:0];
    assign w_cand_ctrl  = (w_cand == TOK_C0) || (w_cand == TOK_C1) ||
                          (w_cand == TOK_C2) || (w_cand == TOK_C3);
    assign w_lock_hit   = w_cand_ctrl && (r_run >= RUN_LAST);
    assign w_run_nxt    = !w_cand_ctrl ? '0 :
                          (r_run == RUN_MAX) ? r_run : r_run + 1'b1;
    assign w_offset_nxt = (r_offset == 4'd9) ? 4'd0 : r_offset + 4'd1;

    // NOTE: all state updates use non-blocking assignments so every register samples
    // the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state           <= ST_SEARCH;
            r_prev            <= '0;
            r_aligned_word    <= '0;
            r_aligned_valid   <= 1'b0;
            r_aligned_is_ctrl <= 1'b0;
            r_locked          <= 1'b0;
            r_offset          <= '0;
            r_lock_lost       <= 1'b0;
            r_run             <= '0;
            r_tmo             <= '0;
            r_gap             <= '0;
        end else begin
            r_lock_lost     <= 1'b0;
            r_aligned_valid <= raw_valid;
            if (raw_valid) begin
                r_aligned_word    <= w_cand;
                r_aligned_is_ctrl <= w_cand_ctrl;
                r_prev            <= raw_word;
                r_run             <= w_run_nxt;
                case (r_state)
                    ST_SEARCH: begin
                        if (w_lock_hit) begin
                            r_state  <= ST_LOCKED;
                            r_locked <= 1'b1;
                            r_gap    <= '0;
                            r_tmo    <= '0;
                        end else if (r_tmo == TMO_LAST) begin
                            r_offset <= w_offset_nxt;
                            r_tmo    <= '0;
                            r_run    <= '0;
                        end else begin
                            r_tmo <= r_tmo + 1'b1;
                        end
                    end
                    ST_LOCKED: begin
                        // A qualified token run keeps lock alive; silence drops it.
                        if (w_lock_hit) begin
                            r_gap <= '0;
                        end else if (r_gap == GAP_LAST) begin
                            r_state     <= ST_SEARCH;
                            r_locked    <= 1'b0;
                            r_lock_lost <= 1'b1;
                            r_run       <= '0;
                            r_tmo       <= '0;
                            r_gap       <= '0;
                        end else begin
                            r_gap <= r_gap + 1'b1;
                        end
                    end
                    default: r_state <= ST_SEARCH;
                endcase
            end
        end
    end

    assign aligned_word    = r_aligned_word;
    assign aligned_valid   = r_aligned_valid;
    assign aligned_is_ctrl = r_aligned_is_ctrl;
    assign locked          = r_locked;
    assign offset          = r_offset;
    assign lock_lost       = r_lock_lost;

endmodule

// File: tb/tb_tmds_word_aligner.sv
// Directed testbench for tmds_word_aligner: reset, aligned lock, bit-slipped search,
// near-miss runs, offset wrap, loss of lock, valid gaps and reset while locked.
module tb_tmds_word_aligner;

    localparam logic [9:0] C0 = 10'b1101010100;
    localparam logic [9:0] C1 = 10'b0010101011;
    localparam logic [9:0] C2 = 10'b0101010100;
    localparam logic [9:0] C3 = 10'b1010101011;
    localparam logic [9:0] DW = 10'h01F;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] raw_word;
    logic       raw_valid;
    logic [9:0] aligned_word;
    logic       aligned_valid;
    logic       aligned_is_ctrl;
    logic       locked;
    logic [3:0] offset;
    logic       lock_lost;

    int checks   = 0;
    int failures = 0;
    int lost_cnt = 0;

    tmds_word_aligner dut (
        .clk            (clk),
        .rst            (rst),
        .raw_word       (raw_word),
        .raw_valid      (raw_valid),
        .aligned_word   (aligned_word),
        .aligned_valid  (aligned_valid),
        .aligned_is_ctrl(aligned_is_ctrl),
        .locked         (locked),
        .offset         (offset),
        .lock_lost      (lock_lost)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (lock_lost === 1'b1) lost_cnt++;

    task automatic beat(input logic [9:0] w);
        raw_word  = w;
        raw_valid = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        raw_word  = 10'($urandom);
        raw_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        raw_valid = 1'b0;
        raw_word  = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    function automatic logic [9:0] tx_word(input int n);
        int pos;
        pos = n % 2200;
        if (pos >= 1920) return C0;
        case (pos % 4)
            0:       return 10'h01F;
            1:       return 10'h3E0;
            2:       return 10'h0FF;
            default: return 10'h300;
        endcase
    endfunction

    task automatic test_reset();
        rst       = 1'b1;
        raw_valid = 1'b1;
        raw_word  = C0;
        @(posedge clk);
        #1;
        checks++; if (aligned_word !== 10'd0) begin failures++; $display("FAIL reset_word got=%h exp=000", aligned_word); end
        checks++; if (aligned_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", aligned_valid); end
        checks++; if (aligned_is_ctrl !== 1'b0) begin failures++; $display("FAIL reset_ctrl got=%b exp=0", aligned_is_ctrl); end
        checks++; if (locked !== 1'b0) begin failures++; $display("FAIL reset_locked got=%b exp=0", locked); end
        checks++; if (offset !== 4'd0) begin failures++; $display("FAIL reset_offset got=%0d exp=0", offset); end
        checks++; if (lock_lost !== 1'b0) begin failures++; $display("FAIL reset_lock_lost got=%b exp=0", lock_lost); end
        rst       = 1'b0;
        raw_valid = 1'b0;
    endtask

    task automatic test_aligned_lock();
        do_reset();
        for (int i = 0; i < 20; i++) begin
            beat(10'h100 + 10'(i));
            checks++; if (aligned_valid !== 1'b1) begin failures++; $display("FAIL t1_valid beat=%0d got=%b exp=1", i, aligned_valid); end
            if (i > 0) begin
                checks++; if (aligned_word !== 10'h100 + 10'(i - 1)) begin failures++; $display("FAIL t1_delay beat=%0d got=%h exp=%h", i, aligned_word, 10'h100 + 10'(i - 1)); end
            end
        end
        for (int j = 0; j < 16; j++) begin
            beat(C0);
            checks++; if (locked !== 1'b0) begin failures++; $display("FAIL t1_early_lock token=%0d got=%b exp=0", j, locked); end
        end
        beat(10'h120);
        checks++; if (locked !== 1'b1) begin failures++; $display("FAIL t1_lock got=%b exp=1", locked); end
        checks++; if (aligned_word !== C0) begin failures++; $display("FAIL t1_lock_word got=%h exp=%h", aligned_word, C0); end
        checks++; if (aligned_is_ctrl !== 1'b1) begin failures++; $display("FAIL t1_is_ctrl got=%b exp=1", aligned_is_ctrl); end
        checks++; if (offset !== 4'd0) begin failures++; $display("FAIL t1_offset got=%0d exp=0", offset); end
        beat(10'h121);
        checks++; if (aligned_word !== 10'h120) begin failures++; $display("FAIL t1_post_word got=%h exp=120", aligned_word); end
        checks++; if (aligned_is_ctrl !== 1'b0) begin failures++; $display("FAIL t1_post_ctrl got=%b exp=0", aligned_is_ctrl); end
    endtask

    task automatic test_rotated_search();
        logic [9:0] tx;
        logic [9:0] tx_prev;
        int lock_beat;
        tx_prev   = '0;
        lock_beat = -1;
        do_reset();
        for (int n = 0; n < 13300; n++) begin
            tx = tx_word(n);
            beat({tx[6:0], tx_prev[9:7]});
            if (n == 4094) begin
                checks++; if (offset !== 4'd0) begin failures++; $display("FAIL t2_offset_pre got=%0d exp=0", offset); end
            end
            if (n == 4095) begin
                checks++; if (offset !== 4'd1) begin failures++; $display("FAIL t2_offset1 got=%0d exp=1", offset); end
            end
            if (n == 8191) begin
                checks++; if (offset !== 4'd2) begin failures++; $display("FAIL t2_offset2 got=%0d exp=2", offset); end
            end
            if (n == 12287) begin
                checks++; if (offset !== 4'd3) begin failures++; $display("FAIL t2_offset3 got=%0d exp=3", offset); end
            end
            if (lock_beat < 0 && locked === 1'b1) begin
                lock_beat = n;
                checks++; if (aligned_word !== C0) begin failures++; $display("FAIL t2_lock_word got=%h exp=%h", aligned_word, C0); end
                checks++; if (offset !== 4'd3) begin failures++; $display("FAIL t2_lock_offset got=%0d exp=3", offset); end
            end else if (lock_beat >= 0) begin
                checks++; if (aligned_word !== tx_prev || locked !== 1'b1) begin
                    failures++;
                    $display("FAIL t2_decode beat=%0d got=%h/%b exp=%h/1", n, aligned_word, locked, tx_prev);
                end
            end
            tx_prev = tx;
        end
        checks++; if (lock_beat != 12936) begin failures++; $display("FAIL t2_lock_beat got=%0d exp=12936", lock_beat); end
    endtask

    task automatic test_near_miss();
        int base;
        bit seen_lock;
        seen_lock = 1'b0;
        do_reset();
        base = lost_cnt;
        for (int n = 0; n < 4160; n++) begin
            beat((n % 16 == 15) ? 10'h100 : C1);
            if (locked === 1'b1) seen_lock = 1'b1;
            if (n == 4094) begin
                checks++; if (offset !== 4'd0) begin failures++; $display("FAIL t3_offset_pre got=%0d exp=0", offset); end
            end
            if (n == 4095) begin
                checks++; if (offset !== 4'd1) begin failures++; $display("FAIL t3_offset1 got=%0d exp=1", offset); end
            end
        end
        checks++; if (seen_lock !== 1'b0) begin failures++; $display("FAIL t3_locked got=%b exp=0", seen_lock); end
        checks++; if (lost_cnt != base) begin failures++; $display("FAIL t3_lock_lost got=%0d exp=0", lost_cnt - base); end
    endtask

    task automatic test_offset_wrap();
        bit seen_lock;
        seen_lock = 1'b0;
        do_reset();
        for (int n = 0; n < 40960; n++) begin
            beat(DW);
            if (locked === 1'b1) seen_lock = 1'b1;
            if (n == 36863 || n == 40958) begin
                checks++; if (offset !== 4'd9) begin failures++; $display("FAIL t4_offset9 beat=%0d got=%0d exp=9", n, offset); end
            end
            if (n == 40959) begin
                checks++; if (offset !== 4'd0) begin failures++; $display("FAIL t4_wrap got=%0d exp=0", offset); end
            end
        end
        checks++; if (seen_lock !== 1'b0) begin failures++; $display("FAIL t4_locked got=%b exp=0", seen_lock); end
    endtask

    task automatic test_loss_relock();
        int base;
        bit early_loss;
        early_loss = 1'b0;
        do_reset();
        for (int j = 0; j < 16; j++) beat(C0);
        beat(DW);
        checks++; if (locked !== 1'b1) begin failures++; $display("FAIL t5_lock got=%b exp=1", locked); end
        base = lost_cnt;
        for (int j = 1; j <= 8192; j++) begin
            beat(DW);
            if (j < 8192 && (lock_lost !== 1'b0 || locked !== 1'b1)) early_loss = 1'b1;
        end
        checks++; if (early_loss !== 1'b0) begin failures++; $display("FAIL t5_early_loss got=%b exp=0", early_loss); end
        checks++; if (lock_lost !== 1'b1) begin failures++; $display("FAIL t5_lock_lost got=%b exp=1", lock_lost); end
        checks++; if (locked !== 1'b0) begin failures++; $display("FAIL t5_unlocked got=%b exp=0", locked); end
        checks++; if (offset !== 4'd0) begin failures++; $display("FAIL t5_offset got=%0d exp=0", offset); end
        beat(DW);
        checks++; if (lock_lost !== 1'b0) begin failures++; $display("FAIL t5_pulse_width got=%b exp=0", lock_lost); end
        checks++; if (lost_cnt - base != 1) begin failures++; $display("FAIL t5_pulse_count got=%0d exp=1", lost_cnt - base); end
        for (int j = 0; j < 16; j++) beat(C2);
        checks++; if (locked !== 1'b0) begin failures++; $display("FAIL t5_relock_early got=%b exp=0", locked); end
        beat(DW);
        checks++; if (locked !== 1'b1 || aligned_word !== C2) begin
            failures++;
            $display("FAIL t5_relock got=%b/%h exp=1/%h", locked, aligned_word, C2);
        end
    endtask

    task automatic test_valid_gap();
        bit bad_idle;
        bad_idle = 1'b0;
        do_reset();
        for (int j = 0; j < 8; j++) beat(C3);
        for (int k = 0; k < 100; k++) begin
            idle();
            if (aligned_valid !== 1'b0 || aligned_word !== C3 || aligned_is_ctrl !== 1'b1 || offset !== 4'd0)
                bad_idle = 1'b1;
        end
        checks++; if (bad_idle !== 1'b0) begin failures++; $display("FAIL t6_idle_hold got=%b exp=0", bad_idle); end
        for (int j = 0; j < 8; j++) beat(C3);
        checks++; if (locked !== 1'b0) begin failures++; $display("FAIL t6_early_lock got=%b exp=0", locked); end
        beat(C3);
        checks++; if (locked !== 1'b1) begin failures++; $display("FAIL t6_lock got=%b exp=1", locked); end
        rst       = 1'b1;
        raw_valid = 1'b1;
        raw_word  = C3;
        @(posedge clk);
        #1;
        checks++; if ({aligned_word, aligned_valid, aligned_is_ctrl, locked, offset, lock_lost} !== 18'd0) begin
            failures++;
            $display("FAIL t6_rst_locked got=%h/%b/%b/%b/%0d/%b exp=all zero",
                     aligned_word, aligned_valid, aligned_is_ctrl, locked, offset, lock_lost);
        end
        rst       = 1'b0;
        raw_valid = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        raw_valid = 1'b0;
        raw_word  = '0;
        test_reset();
        test_aligned_lock();
        test_rotated_search();
        test_near_miss();
        test_offset_wrap();
        test_loss_relock();
        test_valid_gap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
